crg_rst_seq: RTL and testbench



---
 rtl/crg_rst_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_crg_rst_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/crg_rst_seq.sv
// -----------------------------------------------------------------------------
// crg_rst_seq
// Reset / clock-enable sequencer for the clock-and-reset generator. A single
// controller serves NUM_CH derived channels. It waits for a debounced PLL
// lock, then releases the channel resets one after another in a fixed
// staggered order. Each channel gets a programmable clock-enable pulse. The
// channel-0 clock-mux select is switched only while channel 0 is held in
// reset. If the PLL loses lock, every channel reset is reasserted.
//
// Ports
//   clk_src      in   single clock, all logic on the rising edge
//   rst_n_sys    in   synchronous active-low reset
//   pll_locked   in   PLL lock indication, already synchronous to clk_src
//   div_ratio    in   NUM_CH*DIV_W; channel i ratio at [i*DIV_W +: DIV_W];
//                     0 or 1 means enable every cycle
//   mux_sel_req  in   requested channel-0 clock-mux select
//   mux_sel      out  registered select to the channel-0 clock mux
//   rst_n_ch     out  NUM_CH per-channel active-low resets
//   clk_ce       out  NUM_CH per-channel clock-enable pulses
//   seq_done     out  all channels released and no switch in progress
//   lock_lost    out  one-cycle pulse when lock drops after WAIT_LOCK
// -----------------------------------------------------------------------------
module crg_rst_seq #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CNT    = 16,
  parameter int STAGGER     = 8,
  parameter int SWITCH_HOLD = 4
) (
  input  logic                    clk_src,
  input  logic                    rst_n_sys,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    mux_sel_req,
  output logic                    mux_sel,
  output logic [NUM_CH-1:0]       rst_n_ch,
  output logic [NUM_CH-1:0]       clk_ce,
  output logic                    seq_done,
  output logic                    lock_lost
);

  // Each counter only has to reach its terminal value (PARAM-1).
  localparam int LCW = (LOCK_CNT    > 1) ? $clog2(LOCK_CNT)    : 1;
  localparam int SCW = (STAGGER     > 1) ? $clog2(STAGGER)     : 1;
  localparam int HCW = (SWITCH_HOLD > 1) ? $clog2(SWITCH_HOLD) : 1;

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CNT - 1);
  localparam logic [SCW-1:0] STAG_LAST = SCW'(STAGGER - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(SWITCH_HOLD - 1);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_RELEASE   = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_SW_PRE    = 3'd3;
  localparam logic [2:0] S_SW_POST   = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [LCW-1:0]    lock_cnt_q,  lock_cnt_d;
  logic [SCW-1:0]    stag_cnt_q,  stag_cnt_d;
  logic [HCW-1:0]    hold_cnt_q,  hold_cnt_d;
  logic              mux_sel_q,   mux_sel_d;
  logic [NUM_CH-1:0] rst_n_ch_q,  rst_n_ch_d;
  logic [NUM_CH-1:0] clk_ce_q,    clk_ce_d;
  logic              seq_done_q,  seq_done_d;
  logic              lock_lost_q, lock_lost_d;
  logic [DIV_W-1:0]  div_cnt_q [NUM_CH];
  logic [DIV_W-1:0]  div_cnt_d [NUM_CH];
  logic [DIV_W-1:0]  ratio;

  // Sequencer FSM
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    stag_cnt_d  = stag_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    mux_sel_d   = mux_sel_q;
    rst_n_ch_d  = rst_n_ch_q;
    seq_done_d  = seq_done_q;
    lock_lost_d = 1'b0;

    if ((state_q != S_WAIT_LOCK) && !pll_locked) begin
      // Lock loss wins over everything, including a pending mux switch.
      // mux_sel keeps its value here and re-tracks the request in WAIT_LOCK.
      state_d     = S_WAIT_LOCK;
      lock_cnt_d  = '0;
      stag_cnt_d  = '0;
      hold_cnt_d  = '0;
      rst_n_ch_d  = '0;
      seq_done_d  = 1'b0;
      lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          mux_sel_d = mux_sel_req;
          if (!pll_locked) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            lock_cnt_d = '0;
            stag_cnt_d = '0;
            rst_n_ch_d = NUM_CH'(1);
            if (NUM_CH == 1) begin
              state_d    = S_RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end

        S_RELEASE: begin
          if (stag_cnt_q == STAG_LAST) begin
            stag_cnt_d = '0;
            // Channels come out of reset in index order, so shifting a one
            // in from the bottom releases the next channel.
            rst_n_ch_d = (rst_n_ch_q << 1) | NUM_CH'(1);
            if (&rst_n_ch_d) begin
              state_d    = S_RUN;
              seq_done_d = 1'b1;
            end
          end else begin
            stag_cnt_d = stag_cnt_q + SCW'(1);
          end
        end

        S_RUN: begin
          if (mux_sel_req != mux_sel_q) begin
            state_d       = S_SW_PRE;
            hold_cnt_d    = '0;
            rst_n_ch_d[0] = 1'b0;
            seq_done_d    = 1'b0;
          end
        end

        S_SW_PRE: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            mux_sel_d  = ~mux_sel_q;
            state_d    = S_SW_POST;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end

        S_SW_POST: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d    = '0;
            rst_n_ch_d[0] = 1'b1;
            seq_done_d    = 1'b1;
            state_d       = S_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end

        default: begin
          state_d = S_WAIT_LOCK;
        end
      endcase
    end
  end

  // Per-channel dividers. A channel counts only while its reset is high both
  // now and after this edge, so clk_ce is low whenever rst_n_ch is low.
  always_comb begin
    ratio    = '0;
    clk_ce_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_cnt_d[i] = '0;
      ratio        = div_ratio[i*DIV_W +: DIV_W];
      if (ratio == '0) begin
        ratio = DIV_W'(1);
      end
      if (rst_n_ch_q[i] && rst_n_ch_d[i]) begin
        // >= rather than == so a ratio cut below the running count wraps
        // on the very next edge.
        if (div_cnt_q[i] >= (ratio - DIV_W'(1))) begin
          clk_ce_d[i]  = 1'b1;
          div_cnt_d[i] = '0;
        end else begin
          div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Register stage
  always_ff @(posedge clk_src) begin
    if (!rst_n_sys) begin
      state_q     <= S_WAIT_LOCK;
      lock_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      mux_sel_q   <= 1'b0;
      rst_n_ch_q  <= '0;
      clk_ce_q    <= '0;
      seq_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mux_sel_q   <= mux_sel_d;
      rst_n_ch_q  <= rst_n_ch_d;
      clk_ce_q    <= clk_ce_d;
      seq_done_q  <= seq_done_d;
      lock_lost_q <= lock_lost_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt_q[i] <= div_cnt_d[i];
      end
    end
  end

  assign mux_sel   = mux_sel_q;
  assign rst_n_ch  = rst_n_ch_q;
  assign clk_ce    = clk_ce_q;
  assign seq_done  = seq_done_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_crg_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_crg_rst_seq
// Directed bench for crg_rst_seq (NUM_CH=3, LOCK_CNT=16, STAGGER=8,
// SWITCH_HOLD=4). Edge n is the n-th rising edge of clk_src; outputs are
// sampled and inputs driven 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_crg_rst_seq;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;

  logic                    clk_src;
  logic                    rst_n_sys;
  logic                    pll_locked;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic                    mux_sel_req;
  logic                    mux_sel;
  logic [NUM_CH-1:0]       rst_n_ch;
  logic [NUM_CH-1:0]       clk_ce;
  logic                    seq_done;
  logic                    lock_lost;

  int cyc;
  int tests;
  int fails;

  crg_rst_seq #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CNT    (16),
    .STAGGER     (8),
    .SWITCH_HOLD (4)
  ) dut (
    .clk_src     (clk_src),
    .rst_n_sys   (rst_n_sys),
    .pll_locked  (pll_locked),
    .div_ratio   (div_ratio),
    .mux_sel_req (mux_sel_req),
    .mux_sel     (mux_sel),
    .rst_n_ch    (rst_n_ch),
    .clk_ce      (clk_ce),
    .seq_done    (seq_done),
    .lock_lost   (lock_lost)
  );

  initial clk_src = 1'b0;
  always #5 clk_src = ~clk_src;

  task automatic tick();
    @(posedge clk_src);
    cyc++;
    #1;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected clk_ce {ch2,ch1,ch0} on edges 41..54; ch2 ratio drops 5->2
  // after edge 49, when its count is 3.
  logic [2:0] exp_ce [14];

  initial begin
    exp_ce = '{3'b001, 3'b011, 3'b001, 3'b001, 3'b011, 3'b101, 3'b001,
               3'b011, 3'b001, 3'b101, 3'b011, 3'b101, 3'b001, 3'b111};
    cyc         = 0;
    tests       = 0;
    fails       = 0;
    rst_n_sys   = 1'b0;
    pll_locked  = 1'b0;
    mux_sel_req = 1'b0;
    div_ratio   = {8'd5, 8'd3, 8'd0};

    // Reset state
    step_to(1);
    chk("rst_rst_n_ch",  32'(rst_n_ch),  32'h0);
    chk("rst_clk_ce",    32'(clk_ce),    32'h0);
    chk("rst_mux_sel",   32'(mux_sel),   32'h0);
    chk("rst_seq_done",  32'(seq_done),  32'h0);
    chk("rst_lock_lost", 32'(lock_lost), 32'h0);
    step_to(2);
    rst_n_sys = 1'b1;

    // Lock from edge 10: staggered release at 25 / 33 / 41
    step_to(9);
    pll_locked = 1'b1;
    step_to(24);
    chk("s1_rst_e24", 32'(rst_n_ch), 32'h0);
    step_to(25);
    chk("s1_rst_e25", 32'(rst_n_ch), 32'h1);
    chk("s1_ce0_e25", 32'(clk_ce[0]), 32'h0);
    step_to(26);
    chk("s1_ce0_e26", 32'(clk_ce[0]), 32'h1);
    step_to(32);
    chk("s1_rst_e32", 32'(rst_n_ch), 32'h1);
    step_to(33);
    chk("s1_rst_e33", 32'(rst_n_ch), 32'h3);
    step_to(35);
    chk("s3_ce1_e35", 32'(clk_ce[1]), 32'h0);
    step_to(36);
    chk("s3_ce1_e36", 32'(clk_ce[1]), 32'h1);
    step_to(40);
    chk("s1_rst_e40",  32'(rst_n_ch), 32'h3);
    chk("s1_done_e40", 32'(seq_done), 32'h0);
    step_to(41);
    chk("s1_rst_e41",  32'(rst_n_ch), 32'h7);
    chk("s1_done_e41", 32'(seq_done), 32'h1);

    // Divider pattern with mid-period ratio decrease on channel 2
    for (int k = 0; k < 14; k++) begin
      step_to(41 + k);
      chk($sformatf("s3_ce_e%0d", 41 + k), 32'(clk_ce), 32'(exp_ce[k]));
      if (41 + k == 49) div_ratio[23:16] = 8'd2;
    end

    // Mux switch requested after edge 60
    step_to(60);
    mux_sel_req = 1'b1;
    step_to(61);
    chk("s4_rst_e61",  32'(rst_n_ch), 32'h6);
    chk("s4_done_e61", 32'(seq_done), 32'h0);
    chk("s4_mux_e61",  32'(mux_sel),  32'h0);
    step_to(62);
    chk("s4_ce0_e62", 32'(clk_ce[0]), 32'h0);
    step_to(63);
    chk("s4_ce_e63", 32'(clk_ce), 32'h2);
    step_to(64);
    chk("s4_mux_e64", 32'(mux_sel), 32'h0);
    step_to(65);
    chk("s4_mux_e65", 32'(mux_sel),  32'h1);
    chk("s4_rst_e65", 32'(rst_n_ch), 32'h6);
    step_to(66);
    chk("s4_ce_e66", 32'(clk_ce), 32'h6);
    step_to(68);
    chk("s4_rst_e68",  32'(rst_n_ch), 32'h6);
    chk("s4_done_e68", 32'(seq_done), 32'h0);
    step_to(69);
    chk("s4_rst_e69",  32'(rst_n_ch), 32'h7);
    chk("s4_done_e69", 32'(seq_done), 32'h1);
    step_to(70);
    chk("s4_ce0_e70", 32'(clk_ce[0]), 32'h1);

    // Lock loss in RUN, then mux_sel tracks the request in WAIT_LOCK
    step_to(75);
    pll_locked = 1'b0;
    step_to(76);
    chk("ll_rst_e76",  32'(rst_n_ch),  32'h0);
    chk("ll_ce_e76",   32'(clk_ce),    32'h0);
    chk("ll_done_e76", 32'(seq_done),  32'h0);
    chk("ll_pulse_e76", 32'(lock_lost), 32'h1);
    chk("ll_mux_e76",  32'(mux_sel),   32'h1);
    step_to(77);
    chk("ll_pulse_e77", 32'(lock_lost), 32'h0);
    mux_sel_req = 1'b0;
    step_to(78);
    chk("wl_mux_e78", 32'(mux_sel), 32'h0);

    // Re-lock from edge 80, then lose lock during RELEASE after ch1
    step_to(79);
    pll_locked = 1'b1;
    step_to(95);
    chk("s5_rst_e95", 32'(rst_n_ch), 32'h1);
    step_to(103);
    chk("s5_rst_e103", 32'(rst_n_ch), 32'h3);
    step_to(105);
    chk("s5_rst_e105", 32'(rst_n_ch), 32'h3);
    pll_locked = 1'b0;
    step_to(106);
    chk("s5_rst_e106",   32'(rst_n_ch),  32'h0);
    chk("s5_pulse_e106", 32'(lock_lost), 32'h1);
    chk("s5_ce_e106",    32'(clk_ce),    32'h0);
    pll_locked = 1'b1;
    step_to(107);
    chk("s5_pulse_e107", 32'(lock_lost), 32'h0);
    step_to(121);
    chk("s5_rst_e121", 32'(rst_n_ch), 32'h0);
    step_to(122);
    chk("s5_rst_e122", 32'(rst_n_ch), 32'h1);
    step_to(130);
    chk("s5_rst_e130", 32'(rst_n_ch), 32'h3);
    step_to(138);
    chk("s5_rst_e138",  32'(rst_n_ch), 32'h7);
    chk("s5_done_e138", 32'(seq_done), 32'h1);

    // System reset during SW_PRE
    step_to(140);
    mux_sel_req = 1'b1;
    step_to(141);
    chk("s6_rst_e141", 32'(rst_n_ch), 32'h6);
    step_to(142);
    rst_n_sys = 1'b0;
    step_to(143);
    chk("s6_rst_e143",  32'(rst_n_ch),  32'h0);
    chk("s6_ce_e143",   32'(clk_ce),    32'h0);
    chk("s6_mux_e143",  32'(mux_sel),   32'h0);
    chk("s6_done_e143", 32'(seq_done),  32'h0);
    chk("s6_ll_e143",   32'(lock_lost), 32'h0);
    rst_n_sys = 1'b1;
    step_to(144);
    chk("s6_mux_e144", 32'(mux_sel), 32'h1);

    // One-cycle lock glitch at edge 150 restarts the lock count
    step_to(149);
    pll_locked = 1'b0;
    step_to(150);
    pll_locked = 1'b1;
    step_to(165);
    chk("s2_rst_e165", 32'(rst_n_ch), 32'h0);
    step_to(166);
    chk("s2_rst_e166",  32'(rst_n_ch), 32'h1);
    chk("s2_done_e166", 32'(seq_done), 32'h0);
    step_to(174);
    chk("s6_rst_e174", 32'(rst_n_ch), 32'h3);
    step_to(182);
    chk("s6_rst_e182",  32'(rst_n_ch), 32'h7);
    chk("s6_done_e182", 32'(seq_done), 32'h1);
    step_to(186);
    chk("s6_rst_e186", 32'(rst_n_ch), 32'h7);
    chk("s6_mux_e186", 32'(mux_sel),  32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
